data_ram_responder: RTL



---
 rtl/data_ram_responder_pkg.sv | 26 ++
 rtl/data_ram_responder_if.sv | 22 ++
 rtl/data_ram_responder_uart_tx.sv | 98 +++++++++
 rtl/data_ram_responder.sv | 112 +++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// Shared constants and types for the data-RAM responder: MMIO offsets,
// the default MMIO window selector and the UART transmitter state encoding.
package data_ram_responder_pkg;

    // addr[31:16] value that selects the MMIO window
    localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'hBFAF;

    // Register offsets inside the MMIO window (byte offsets, word aligned)
    localparam logic [15:0] OFF_LED         = 16'hF000;
    localparam logic [15:0] OFF_COUNTER     = 16'hF010;
    localparam logic [15:0] OFF_UART_DATA   = 16'hF020;
    localparam logic [15:0] OFF_UART_STATUS = 16'hF024;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Word-granular offset compare; the byte-select bits [1:0] never matter
    function automatic logic off_match(input logic [15:0] addr_lo, input logic [15:0] off);
        return addr_lo[15:2] == off[15:2];
    endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// CPU data-RAM port bundle. Signal names keep the responder's point of view
// (_i = into the responder, _o = out of the responder).
interface data_ram_responder_if;
    logic        ram_en_i;
    logic        ram_write_en_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [3:0]  ram_select_i;
    logic [31:0] ram_data_o;

    // CPU side
    modport master (
        output ram_en_i, ram_write_en_i, ram_addr_i, ram_data_i, ram_select_i,
        input  ram_data_o
    );

    // Responder side
    modport slave (
        input  ram_en_i, ram_write_en_i, ram_addr_i, ram_data_i, ram_select_i,
        output ram_data_o
    );
endinterface

// File: rtl/data_ram_responder_uart_tx.sv
// 8N1 UART transmitter. A start pulse while idle latches the byte and sends
// start bit, 8 data bits LSB first and a stop bit, CLKS_PER_BIT cycles each.
// Start pulses while busy are ignored.
module data_ram_responder_uart_tx
    import data_ram_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;

    // State register; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: baud counter and bit index both count down to zero
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            UART_IDLE: begin
                if (start_i) begin
                    state_d = UART_START;
                    baud_d  = BAUD_RELOAD;
                    shift_d = data_i;
                end
            end
            UART_START: begin
                if (baud_q == '0) begin
                    state_d   = UART_DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd7;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            UART_DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd0) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            UART_STOP: begin
                if (baud_q == '0) begin
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Line level and busy flag decoded straight from the state register
    always_comb begin
        tx_o   = 1'b1;
        busy_o = (state_q != UART_IDLE);
        case (state_q)
            UART_START: tx_o = 1'b0;
            UART_DATA:  tx_o = shift_q[0];
            default:    tx_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder for the CPU data-RAM port: word-addressed data memory
// with byte-lane writes and zero-latency reads, plus an MMIO window holding
// an LED register, a free-running cycle counter and a UART transmitter.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_responder_if.slave  ram_if,
    output logic [15:0]          led_o,
    output logic                 uart_tx_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  mmio_sel;
    logic [15:0]           mmio_off;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic                  store_acc;
    logic                  load_acc;
    logic                  mem_we;
    logic [31:0]           mem_rd;
    logic [31:0]           mmio_rd;
    logic [15:0]           led_q;
    logic [31:0]           counter_q;
    logic                  uart_start;
    logic                  uart_busy;
    logic                  unused_addr_bits;

    // Address decode; address bits above the memory index simply alias
    assign mmio_sel   = (ram_if.ram_addr_i[31:16] == MMIO_BASE_HI);
    assign mmio_off   = ram_if.ram_addr_i[15:0];
    assign mem_idx    = ram_if.ram_addr_i[ADDR_WIDTH+1:2];
    assign store_acc  = ram_if.ram_en_i &  ram_if.ram_write_en_i;
    assign load_acc   = ram_if.ram_en_i & ~ram_if.ram_write_en_i;
    assign mem_we     = store_acc & ~mmio_sel;
    assign unused_addr_bits = ^ram_if.ram_addr_i[1:0];

    // One byte-wide array per lane so each lane write stays independent
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem_q [DEPTH];

            // Byte-lane store; memory contents are deliberately not reset
            always_ff @(posedge clk) begin
                if (mem_we && ram_if.ram_select_i[gi]) begin
                    lane_mem_q[mem_idx] <= ram_if.ram_data_i[8*gi +: 8];
                end
            end

            assign mem_rd[8*gi +: 8] = lane_mem_q[mem_idx];
        end
    endgenerate

    // LED register, written per lanes 0/1
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else if (store_acc && mmio_sel && off_match(mmio_off, OFF_LED)) begin
            if (ram_if.ram_select_i[0]) led_q[7:0]  <= ram_if.ram_data_i[7:0];
            if (ram_if.ram_select_i[1]) led_q[15:8] <= ram_if.ram_data_i[15:8];
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_q + 32'd1;
        end
    end

    // A UART write is only accepted while the transmitter is idle
    assign uart_start = store_acc && mmio_sel && off_match(mmio_off, OFF_UART_DATA)
                        && ram_if.ram_select_i[0] && !uart_busy;

    data_ram_responder_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (uart_start),
        .data_i  (ram_if.ram_data_i[7:0]),
        .busy_o  (uart_busy),
        .tx_o    (uart_tx_o)
    );

    // Load data mux: MMIO read-back or memory word, zero unless a load
    always_comb begin
        mmio_rd = '0;
        if (off_match(mmio_off, OFF_LED)) begin
            mmio_rd = {16'h0000, led_q};
        end else if (off_match(mmio_off, OFF_COUNTER)) begin
            mmio_rd = counter_q;
        end else if (off_match(mmio_off, OFF_UART_STATUS)) begin
            mmio_rd = {31'd0, uart_busy};
        end
        ram_if.ram_data_o = '0;
        if (load_acc) begin
            ram_if.ram_data_o = mmio_sel ? mmio_rd : mem_rd;
        end
    end

    assign led_o = led_q;

endmodule
